// File: rtl/dsp_arbiter.sv
// Two-requester arbiter that time-shares one external add/sub unit.
// A request is granted in IDLE, its operands are held on the shared unit
// for OP_CYCLES cycles, and the captured result is offered until consumed.
module dsp_arbiter #(
  parameter int unsigned OP_CYCLES = 1,
  localparam int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic [DATA_W-1:0] dsp_input1,
  output logic [DATA_W-1:0] dsp_input2,
  output logic              dsp_addorsub,
  input  logic [DATA_W-1:0] dsp_out,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic               sub_q;
  logic               gid_q;
  logic               last_q;
  logic               accept_c;
  logic               grant_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, round-robin grant selection and combinational accept
  always_comb begin
    state_nxt  = state;
    accept_c   = 1'b0;
    grant_c    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // last_q holds the requester whose operation completed last
    if (req0_valid && req1_valid) begin
      grant_c = ~last_q;
    end else begin
      grant_c = req1_valid;
    end
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept_c  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      accept_c = 1'b0;
    end
    req0_ready = accept_c && !grant_c;
    req1_ready = accept_c && grant_c;
  end

  // Operand latch, execute counter, result capture and fairness pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
      rsp_data <= '0;
    end else begin
      if (accept_c) begin
        a_q   <= grant_c ? req1_a : req0_a;
        b_q   <= grant_c ? req1_b : req0_b;
        sub_q <= grant_c ? req1_sub : req0_sub;
        gid_q <= grant_c;
        cnt_q <= '0;
      end else if (state == EXEC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          rsp_data <= dsp_out;
        end
      end
      if ((state == RESP) && rsp_ready) begin
        last_q <= gid_q;
      end
    end
  end

  // Shared-unit operands are only non-zero while executing
  assign dsp_input1   = (!rst && (state == EXEC)) ? a_q : '0;
  assign dsp_input2   = (!rst && (state == EXEC)) ? b_q : '0;
  assign dsp_addorsub = !rst && (state == EXEC) && sub_q;

  // Response routing and status decode
  assign rsp0_valid = !rst && (state == RESP) && !gid_q;
  assign rsp1_valid = !rst && (state == RESP) && gid_q;
  assign busy       = !rst && (state != IDLE);

endmodule

// File: tb/tb_dsp_arbiter.sv
// Bench for dsp_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_dsp_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, req0_sub, req1_sub, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready, dsp_addorsub, rsp0_valid, rsp1_valid, busy;
  logic [31:0] dsp_input1, dsp_input2, dsp_out, rsp_data;

  logic        req0_ready_4, req1_ready_4, dsp_addorsub_4, rsp0_valid_4, rsp1_valid_4, busy_4;
  logic [31:0] dsp_input1_4, dsp_input2_4, dsp_out_4, rsp_data_4;

  // Behavioural model of the shared adder for each instance
  assign dsp_out   = dsp_addorsub   ? dsp_input1 - dsp_input2     : dsp_input1 + dsp_input2;
  assign dsp_out_4 = dsp_addorsub_4 ? dsp_input1_4 - dsp_input2_4 : dsp_input1_4 + dsp_input2_4;

  dsp_arbiter #(.OP_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .dsp_input1(dsp_input1), .dsp_input2(dsp_input2), .dsp_addorsub(dsp_addorsub), .dsp_out(dsp_out),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  dsp_arbiter #(.OP_CYCLES(4)) u4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_4), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready_4), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .dsp_input1(dsp_input1_4), .dsp_input2(dsp_input2_4), .dsp_addorsub(dsp_addorsub_4), .dsp_out(dsp_out_4),
    .rsp0_valid(rsp0_valid_4), .rsp1_valid(rsp1_valid_4), .rsp_ready(rsp_ready), .rsp_data(rsp_data_4),
    .busy(busy_4)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; req0_sub = 1'b0; req1_sub = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
  endtask

  // One-cycle synchronous reset of both instances, checking reset values
  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk2("rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    chk32("rst_dsp1", dsp_input1, 32'h0);
    chk1("rst_busy4", busy_4, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk32("rst_data", rsp_data, 32'h0);
    chk32("rst_data4", rsp_data_4, 32'h0);
    chk1("rst_idle", busy, 1'b0);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[6];

  // Single isolated request on u1 with rsp_ready high: ready at T, result at T+2
  task automatic run_vec(input vec_t v);
    next_cycle();
    rsp_ready = 1'b1;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sub = v.sub;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sub = v.sub;
    end
    @(negedge clk);
    chk2("vec_ready", {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~v.a; req1_a = ~v.a; req0_b = 32'h5a5a_5a5a; req1_b = 32'h5a5a_5a5a;
    @(negedge clk);
    chk32("vec_dsp1", dsp_input1, v.a);
    chk32("vec_dsp2", dsp_input2, v.b);
    chk1("vec_sub", dsp_addorsub, v.sub);
    next_cycle();
    @(negedge clk);
    chk2("vec_rsp", {rsp1_valid, rsp0_valid}, v.id ? 2'b10 : 2'b01);
    chk32("vec_data", rsp_data, v.res);
    chk32("vec_dsp_idle", dsp_input1, 32'h0);
    next_cycle();
    @(negedge clk);
    chk1("vec_done", busy, 1'b0);
  endtask

  // Randomized traffic on u1 against a transaction-level model
  task automatic random_run(input int ncyc);
    localparam int OP = 1;
    bit          pend, pid, psub, ptr, idle, in_exec, in_resp, exp_r0, exp_r1;
    logic [31:0] pa, pb, pres;
    int          acc, free_at;
    pend = 1'b0; pid = 1'b0; psub = 1'b0; ptr = 1'b0;
    pa = '0; pb = '0; pres = '0; acc = 0; free_at = 0;
    for (int c = 0; c < ncyc; c++) begin
      next_cycle();
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom(); req0_b = $urandom(); req0_sub = 1'($urandom_range(0, 1));
      req1_a = $urandom(); req1_b = $urandom(); req1_sub = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (rst) begin
        chk2("rnd_rst_ready", {req1_ready, req0_ready}, 2'b00);
        chk2("rnd_rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        chk1("rnd_rst_busy", busy, 1'b0);
        chk32("rnd_rst_dsp1", dsp_input1, 32'h0);
        pend = 1'b0; ptr = 1'b0; free_at = c + 1;
      end else begin
        idle    = !pend && (c >= free_at);
        in_exec = pend && (c > acc) && (c <= acc + OP);
        in_resp = pend && (c > acc + OP);
        exp_r0  = idle && req0_valid && (!req1_valid || !ptr);
        exp_r1  = idle && req1_valid && (!req0_valid || ptr);
        chk2("rnd_ready", {req1_ready, req0_ready}, {exp_r1, exp_r0});
        chk1("rnd_busy", busy, !idle);
        chk2("rnd_rsp", {rsp1_valid, rsp0_valid}, {in_resp && pid, in_resp && !pid});
        if (in_resp) chk32("rnd_data", rsp_data, pres);
        chk32("rnd_dsp1", dsp_input1, in_exec ? pa : 32'h0);
        chk32("rnd_dsp2", dsp_input2, in_exec ? pb : 32'h0);
        chk1("rnd_dsp_sub", dsp_addorsub, in_exec && psub);
        if (in_resp && rsp_ready) begin
          pend = 1'b0; ptr = !pid; free_at = c + 1;
        end else if (exp_r0 || exp_r1) begin
          pend = 1'b1; pid = exp_r1; acc = c;
          pa   = exp_r1 ? req1_a : req0_a;
          pb   = exp_r1 ? req1_b : req0_b;
          psub = exp_r1 ? req1_sub : req0_sub;
          pres = psub ? pa - pb : pa + pb;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF};
    vecs[5] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention: both valid from reset, grants alternate 0,1,0,1
    next_cycle();
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd50;  req1_b = 32'd8; req1_sub = 1'b1;
    @(negedge clk);
    chk2("cont_rst_ready", {req1_ready, req0_ready}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk2("cont_grant", {req1_ready, req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
      next_cycle();
      @(negedge clk);
      chk2("cont_exec_ready", {req1_ready, req0_ready}, 2'b00);
      next_cycle();
      @(negedge clk);
      chk2("cont_rsp", {rsp1_valid, rsp0_valid}, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk32("cont_data", rsp_data, (k % 2 == 1) ? 32'd42 : 32'd101);
    end

    // Backpressure: result held for 5 cycles with both requesters waiting
    next_cycle();
    req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_sub = 1'b0;
    @(negedge clk);
    chk2("bp_accept", {req1_ready, req0_ready}, 2'b01);
    next_cycle();
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_sub = 1'b0;
    req0_a = 32'hFFFF_0000;
    @(negedge clk);
    chk2("bp_exec_ready", {req1_ready, req0_ready}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk2("bp_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
      chk32("bp_data", rsp_data, 32'd16);
      chk2("bp_ready", {req1_ready, req0_ready}, 2'b00);
      chk1("bp_busy", busy, 1'b1);
    end
    next_cycle();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk2("bp_handshake", {rsp1_valid, rsp0_valid}, 2'b01);
    next_cycle();
    @(negedge clk);
    chk2("bp_rr_next", {req1_ready, req0_ready}, 2'b10);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk2("bp_req1_rsp", {rsp1_valid, rsp0_valid}, 2'b10);
    chk32("bp_req1_data", rsp_data, 32'd7);

    // OP_CYCLES=4: operands held exactly 4 cycles, result 5 cycles after accept
    do_reset();
    next_cycle();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h1111_1111; req0_b = 32'h2222_2222; req0_sub = 1'b1;
    @(negedge clk);
    chk2("op4_accept", {req1_ready_4, req0_ready_4}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      req0_valid = 1'b0; req0_a = 32'h0; req0_b = 32'h0;
      @(negedge clk);
      chk32("op4_dsp1", dsp_input1_4, 32'h1111_1111);
      chk32("op4_dsp2", dsp_input2_4, 32'h2222_2222);
      chk1("op4_sub", dsp_addorsub_4, 1'b1);
      chk2("op4_no_rsp", {rsp1_valid_4, rsp0_valid_4}, 2'b00);
    end
    next_cycle();
    @(negedge clk);
    chk2("op4_rsp", {rsp1_valid_4, rsp0_valid_4}, 2'b01);
    chk32("op4_data", rsp_data_4, 32'hEEEE_EEEF);
    chk32("op4_dsp_off", dsp_input1_4, 32'h0);
    next_cycle();
    @(negedge clk);
    chk1("op4_idle", busy_4, 1'b0);

    // Reset mid-EXEC on u4: op abandoned, priority returns to requester 0
    next_cycle();
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd5; req1_sub = 1'b0;
    @(negedge clk);
    chk2("rx_accept", {req1_ready_4, req0_ready_4}, 2'b10);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk1("rx_rst_busy", busy_4, 1'b0);
    chk32("rx_rst_dsp1", dsp_input1_4, 32'h0);
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_sub = 1'b0;
    req1_valid = 1'b1;
    @(negedge clk);
    chk2("rx_after_rsp", {rsp1_valid_4, rsp0_valid_4}, 2'b00);
    chk32("rx_after_data", rsp_data_4, 32'h0);
    chk2("rx_grant0", {req1_ready_4, req0_ready_4}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk2("rx_no_stale_rsp", {rsp1_valid_4, rsp0_valid_4}, 2'b00);
    end
    next_cycle();
    @(negedge clk);
    chk2("rx_new_rsp", {rsp1_valid_4, rsp0_valid_4}, 2'b01);
    chk32("rx_new_data", rsp_data_4, 32'd7);

    do_reset();
    random_run(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_arbiter.md
DSP_ARBITER -- requirements
Module: dsp_arbiter

Interface
REQ-001 Parameter OP_CYCLES, default 1, meaning: cycles operands are held on the shared adder before the result is captured (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 dsp_input1, dsp_input2  output  32 each  operands to the shared dsp adder.
REQ-010 dsp_addorsub  output  1  add/sub select to the shared dsp adder.
REQ-011 dsp_out  input  32  combinational result from the shared dsp adder.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  result available for requester 0/1.
REQ-013 rsp_ready  input  1  owning requester consumes the result.
REQ-014 rsp_data  output  32  registered result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; encoding free.
REQ-017 IDLE: if neither valid, stay IDLE; otherwise grant one requester, assert its reqN_ready combinationally in that cycle only, latch its a/b/sub and grant id, clear cycle counter, go EXEC.
REQ-018 Arbitration: if only one valid, grant it; if both valid, grant the requester not granted last (round-robin pointer).
REQ-019 Round-robin pointer updates only on a completed RESP handshake; after reset, requester 0 has priority.
REQ-020 reqN_ready is never asserted outside IDLE and never for both requesters in one cycle.
REQ-021 EXEC: dsp_input1 = latched a, dsp_input2 = latched b, dsp_addorsub = latched sub, stable for all EXEC cycles; counter increments each cycle.
REQ-022 EXEC lasts exactly OP_CYCLES cycles; in the last EXEC cycle, dsp_out is registered into rsp_data and the FSM goes to RESP.
REQ-023 In IDLE and RESP, dsp_input1, dsp_input2 and dsp_addorsub are driven 0.
REQ-024 RESP: rspN_valid high for granted N only; rsp_data holds steady; stay until rsp_ready is high, then go IDLE in the next cycle.
REQ-025 rsp_ready while not in RESP is ignored.
REQ-026 Arithmetic is modulo 2^32, no carry/borrow output: sub=0 gives a+b, sub=1 gives a-b.
REQ-027 Latency with OP_CYCLES=1 and rsp_ready held high: accept at cycle T, rspN_valid at T+2, next accept possible at T+3.
REQ-028 Requester operand changes after acceptance have no effect on the in-flight operation.
REQ-029 A requester dropping valid before grant is never granted for that request.

Reset
REQ-030 While rst is high: state IDLE, counter 0, rsp_data 0, rsp0_valid/rsp1_valid/req0_ready/req1_ready/busy 0, dsp outputs 0, round-robin pointer favours requester 0.
REQ-031 rst asserted in EXEC or RESP abandons the operation: no rspN_valid is produced for it, and the next grant after reset follows REQ-030 priority.

Verification
REQ-032 Single add: req0 a=0x0000_0005, b=0x0000_0003, sub=0, OP_CYCLES=1 -> req0_ready at T, rsp0_valid at T+2, rsp_data=0x0000_0008.
REQ-033 Subtract wrap: req1 a=0x0000_0000, b=0x0000_0001, sub=1 -> rsp1_valid, rsp_data=0xFFFF_FFFF, rsp0_valid stays 0.
REQ-034 Contention: both valid continuously from reset -> grants alternate 0,1,0,1; each result routes to the correct rspN_valid.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp0_valid and rsp_data stable, no reqN_ready asserted, busy=1.
REQ-036 OP_CYCLES=4: dsp_input1/2 stable for exactly 4 cycles; rspN_valid first asserted 5 cycles after acceptance.
REQ-037 Reset mid-EXEC: rst pulsed during EXEC -> all outputs 0 the next cycle, no rspN_valid for the abandoned op, next simultaneous request grants requester 0.
